// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch front end of the RV32I core. Holds the fetch PC and requests one
// instruction word per cycle from program memory. Each accepted word is queued
// with its PC in a small prefetch FIFO that feeds decode. A redirect flushes the
// FIFO and either restarts fetching at the target (aligned) or parks the block
// in a fault state until an aligned redirect or reset (misaligned).
//
// Ports
//   i_clk                  clock, rising edge
//   i_rst                  synchronous active-high reset
//   o_pc                   fetch address to program memory (pc register)
//   o_instruction_request  fetch request
//   i_instruction          instruction word from memory
//   i_ack                  memory acknowledge (may be combinational from request)
//   i_redirect             one-cycle redirect strobe
//   i_redirect_pc          redirect target
//   o_valid                head-of-FIFO instruction available to decode
//   o_instruction          head-of-FIFO instruction word
//   o_instruction_pc       PC of the head-of-FIFO instruction
//   i_ready                decode accepts the head this cycle
//   o_fault                instruction-address-misaligned fault pending
//   o_fault_pc             offending redirect target
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_pc,
  output logic        o_instruction_request,
  input  logic [31:0] i_instruction,
  input  logic        i_ack,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_instruction,
  output logic [31:0] o_instruction_pc,
  input  logic        i_ready,
  output logic        o_fault,
  output logic [31:0] o_fault_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  logic [0:0]       state_reg;
  logic [31:0]      pc_reg;
  logic [31:0]      fault_pc_reg;
  logic [CNT_W-1:0] count_reg;
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;

  // Prefetch storage: instruction word and its PC per entry.
  logic [31:0] fifo_instr_reg [FIFO_DEPTH];
  logic [31:0] fifo_pc_reg    [FIFO_DEPTH];

  logic push;
  logic pop;
  logic redirect_aligned;

  // The request looks only at the registered count: a pop in the same cycle
  // does not free a slot for this cycle's fetch (no full-FIFO bypass).
  assign o_instruction_request = !i_rst && (state_reg == ST_FETCH) &&
                                 (count_reg < DEPTH_C) && !i_redirect;
  assign o_valid               = !i_rst && (count_reg != '0) && !i_redirect;
  assign o_fault               = !i_rst && (state_reg == ST_FAULT);
  assign o_fault_pc            = fault_pc_reg;
  assign o_pc                  = pc_reg;
  assign o_instruction         = fifo_instr_reg[head_reg];
  assign o_instruction_pc      = fifo_pc_reg[head_reg];

  assign push             = o_instruction_request && i_ack;
  assign pop              = o_valid && i_ready;
  assign redirect_aligned = (i_redirect_pc[1:0] == 2'b00);

  // Control state: reset beats redirect beats transfer/pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= ST_FETCH;
      pc_reg       <= RESET_PC;
      fault_pc_reg <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
    end else if (i_redirect) begin
      count_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      if (redirect_aligned) begin
        pc_reg    <= i_redirect_pc;
        state_reg <= ST_FETCH;
      end else begin
        // Fetch address is left alone; only the fault record changes.
        fault_pc_reg <= i_redirect_pc;
        state_reg    <= ST_FAULT;
      end
    end else begin
      if (push) begin
        pc_reg   <= pc_reg + 32'd4;
        tail_reg <= tail_reg + 1'b1;
      end
      if (pop) begin
        head_reg <= head_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when counted as valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_instr_reg[tail_reg] <= i_instruction;
      fifo_pc_reg[tail_reg]    <= pc_reg;
    end
  end

endmodule
